// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared constants for the serial byte link receiver
package serial_link_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int GAP_CYCLES_DEF = 4096;

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/in_sync.sv
// rtl/in_sync.sv - pin synchroniser for sclk/sdata with sclk edge detection
module in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_i,
    input  logic sdata_i,
    output logic sdata_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sdata_sync_q;
    logic                   sclk_prev_q;
    logic                   sclk_cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            sclk_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata_i};
            sclk_prev_q  <= sclk_cur;
        end
    end

    // Data is taken from the same stage as the sclk level used for edge detection.
    assign sclk_cur    = sclk_sync_q[SYNC_STAGES-1];
    assign sdata_o     = sdata_sync_q[SYNC_STAGES-1];
    assign sclk_rise_o = ~sclk_prev_q & sclk_cur;
    assign sclk_fall_o = sclk_prev_q & ~sclk_cur;

endmodule

// File: rtl/serial_byte_rx.sv
// rtl/serial_byte_rx.sv - serial byte receiver; optional SEQ_CHECK_EN sequence checker
import serial_link_pkg::*;

module serial_byte_rx #(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_i,
    input  logic              sdata_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              overrun_o,
    output logic [7:0]        err_cnt_o
);

    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GW  = $clog2(GAP_CYCLES + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);
    localparam logic [GW-1:0]  GAP_MAX  = GW'(GAP_CYCLES);

    logic sdata, sclk_rise, sclk_fall;

    in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_in_sync (
        .clk        (clk),
        .rst        (rst),
        .sclk_i     (sclk_i),
        .sdata_i    (sdata_i),
        .sdata_o    (sdata),
        .sclk_rise_o(sclk_rise),
        .sclk_fall_o(sclk_fall)
    );

    logic [0:0]        state_q, state_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_base, word_in;
    logic [GW-1:0]     gap_q, gap_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d;
    logic              word_done, gap_resync;

    // HUNT starts a fresh word from zero so the first bit lands in shift[0].
    assign shift_base = (state_q == ST_HUNT) ? '0 : shift_q;
    assign word_in    = MSB_FIRST ? {shift_base[DATA_W-2:0], sdata}
                                  : {sdata, shift_base[DATA_W-1:1]};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        word_done  = 1'b0;
        gap_resync = 1'b0;

        if (sclk_rise || sclk_fall) begin
            gap_d = '0;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + GW'(1);
        end else begin
            gap_d = gap_q;
        end

        if (state_q == ST_HUNT) begin
            if (sclk_fall) begin
                shift_d   = word_in;
                bit_cnt_d = BCW'(1);
                state_d   = ST_RECV;
            end
        end else begin
            if (sclk_fall) begin
                shift_d = word_in;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    word_done = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end else if (gap_q == GAP_MAX) begin
                state_d    = ST_HUNT;
                bit_cnt_d  = '0;
                gap_resync = 1'b1;
            end
        end
    end

    // Holding register: a completion may replace a word being accepted this cycle.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        if (word_done) begin
            if (!rx_valid_q || rx_ready_i) begin
                rx_data_d  = word_in;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            gap_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            gap_q      <= gap_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign overrun_o  = overrun_q;

`ifdef SEQ_CHECK_EN
    logic [DATA_W-1:0] last_q;
    logic              seeded_q;
    logic [7:0]        err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= '0;
            seeded_q <= 1'b0;
            err_q    <= '0;
        end else if (word_done) begin
            if (seeded_q && (word_in != last_q + DATA_W'(1)) && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
            last_q   <= word_in;
            seeded_q <= 1'b1;
        end else if (gap_resync) begin
            seeded_q <= 1'b0;
        end
    end

    assign err_cnt_o = err_q;
`else
    assign err_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_serial_byte_rx.sv
// tb/tb_serial_byte_rx.sv - scoreboard bench for serial_byte_rx
`timescale 1ns/1ps
module tb_serial_byte_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk_i;
    logic       sdata_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       overrun_o;
    logic [7:0] err_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    serial_byte_rx dut (
        .clk       (clk),
        .rst       (rst),
        .sclk_i    (sclk_i),
        .sdata_i   (sdata_i),
        .rx_data_o (rx_data_o),
        .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i),
        .overrun_o (overrun_o),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] val, input int nbits);
        logic [7:0] v;
        v = val;
        for (int i = 7; i > 7 - nbits; i--) begin
            sclk_i  = 1'b1;
            sdata_i = v[i];
            wait_clk(32);
            sclk_i  = 1'b0;
            wait_clk(32);
        end
    endtask

    task automatic send_byte(input logic [7:0] val, input bit expect_out);
        if (expect_out) exp_q.push_back(val);
        send_bits(val, 8);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) wait_clk(1);
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: a transfer happens at the next posedge when valid&ready is seen here.
    always @(negedge clk) begin
        #1;
        if (!rst && rx_valid_o && rx_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {24'd0, rx_data_o}, 32'hFFFF_FFFF);
            end else begin
                check("rx_data", {24'd0, rx_data_o}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    logic [7:0] exp_err;

    initial begin
        rst        = 1'b1;
        sclk_i     = 1'b0;
        sdata_i    = 1'b0;
        rx_ready_i = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sclk_i  = ~sclk_i;
            sdata_i = ~sdata_i;
        end
        wait_clk(1);
        check("rst_valid",   rx_valid_o, 0);
        check("rst_data",    rx_data_o,  0);
        check("rst_overrun", overrun_o,  0);
        check("rst_err",     err_cnt_o,  0);
        sclk_i  = 1'b0;
        sdata_i = 1'b0;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(10);

        send_byte(8'hA5, 1'b1);
        drain("drain_a5");

        wait_clk(4200);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        drain("drain_seq012");
        check("err_after_012", err_cnt_o, 0);

        send_bits(8'hB8, 5);
        wait_clk(4200);
        send_byte(8'h3C, 1'b1);
        drain("drain_3c");
        check("overrun_before", overrun_o, 0);

        @(negedge clk);
        rx_ready_i = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        wait_clk(8);
        check("hold_valid",   rx_valid_o, 1);
        check("hold_data",    rx_data_o,  32'h11);
        check("overrun_set",  overrun_o,  1);
        rx_ready_i = 1'b1;
        drain("drain_11");
        wait_clk(2);
        check("valid_cleared", rx_valid_o, 0);
        check("overrun_sticky", overrun_o, 1);

        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        check("rst2_overrun", overrun_o, 0);
        check("rst2_err",     err_cnt_o, 0);

        send_byte(8'h05, 1'b1);
        send_byte(8'h06, 1'b1);
        send_byte(8'h08, 1'b1);
        send_byte(8'h09, 1'b1);
        drain("drain_seq_err");
`ifdef SEQ_CHECK_EN
        exp_err = 8'd1;
`else
        exp_err = 8'd0;
`endif
        check("err_cnt", err_cnt_o, {24'd0, exp_err});

        wait_clk(20);
        check("queue_empty_end", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
